// File: rtl/zigbee_cmd_tx_if.sv
// Operator-input / UART-status bundle between the remote front panel and zigbee_cmd_tx.
// master drives the operator inputs; slave is the encoder/transmitter.
interface zigbee_cmd_tx_if;
  logic [1:0] cmd_mode;
  logic [1:0] ctrl_sub;
  logic [1:0] steer;
  logic [1:0] drive;
  logic [5:0] speed_set;
  logic [1:0] func_sel;
  logic       park_btn;
  logic       send_now;
  logic       txd;
  logic       busy;
  logic       tx_done;
  logic [7:0] cmd_byte;

  modport master (
    output cmd_mode, ctrl_sub, steer, drive, speed_set, func_sel, park_btn, send_now,
    input  txd, busy, tx_done, cmd_byte
  );

  modport slave (
    input  cmd_mode, ctrl_sub, steer, drive, speed_set, func_sel, park_btn, send_now,
    output txd, busy, tx_done, cmd_byte
  );
endinterface

// File: rtl/zigbee_cmd_tx.sv
// Car command encoder + UART transmitter (8N1, or 8E1 when ZIGBEE_TX_PARITY_EN is defined)
// driving the Zigbee module TX pin; sends on change, on request and on a periodic refresh.
module zigbee_cmd_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int REFRESH_MS = 100
) (
  input  logic           clk_50M,
  input  logic           rst,
  zigbee_cmd_tx_if.slave bus
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CYC_W   = $clog2(BIT_CYC + 1);
  localparam int MS_CYC  = CLK_HZ / 1000;
  localparam int PRE_W   = $clog2(MS_CYC + 1);
  localparam int MS_W    = (REFRESH_MS > 0) ? $clog2(REFRESH_MS + 1) : 1;
  localparam logic [7:0] FREE_RUN = 8'hC0;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic [7:0] encode(
    input logic [1:0] mode, input logic [1:0] sub, input logic [1:0] st,
    input logic [1:0] dr, input logic [5:0] spd, input logic [1:0] fn, input logic park
  );
    case (mode)
      2'b00:   return {2'b00, sub, norm_dir(st), norm_dir(dr)};
      2'b01:   return {2'b01, spd};
      2'b10:   return {2'b10, fn, 3'b000, park};
      default: return FREE_RUN;
    endcase
  endfunction

  state_t           state;
  logic [7:0]       cmd_byte_p1;
  logic             park_flag;
  logic             park_p1;
  logic [7:0]       last_sent;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [2:0]       bit_idx;
  logic [CYC_W-1:0] cyc_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             pend;
  logic             txd_r;
  logic             busy_r;
  logic             tx_done_r;

  logic refresh_due;
  logic trigger;
  logic frame_start;
  logic bit_end;
  logic park_rise;

  assign refresh_due = (REFRESH_MS != 0) && (ms_cnt >= MS_W'(REFRESH_MS));
  assign trigger     = (cmd_byte_p1 != last_sent) || refresh_due || bus.send_now || pend;
  assign frame_start = (state == IDLE) && trigger;
  assign bit_end     = (cyc_cnt == CYC_W'(BIT_CYC - 1));
  assign park_rise   = bus.park_btn && !park_p1;

  // encode stage: operator inputs -> command byte, one cycle
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cmd_byte_p1 <= FREE_RUN;
      park_flag   <= 1'b0;
      park_p1     <= 1'b0;
    end else begin
      park_p1 <= bus.park_btn;
      if (park_rise && bus.cmd_mode == 2'b10 && bus.func_sel == 2'b01)
        park_flag <= ~park_flag;
      cmd_byte_p1 <= encode(bus.cmd_mode, bus.ctrl_sub, bus.steer, bus.drive,
                            bus.speed_set, bus.func_sel, park_flag);
    end
  end

  // refresh timer runs in every state; only a frame start restarts it
  always_ff @(posedge clk_50M) begin
    if (rst || frame_start) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (pre_cnt == PRE_W'(MS_CYC - 1)) begin
      pre_cnt <= '0;
      if (REFRESH_MS != 0 && !refresh_due)
        ms_cnt <= ms_cnt + MS_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst || frame_start)
      pend <= 1'b0;
    else if (bus.send_now)
      pend <= 1'b1;
  end

  // serialiser: start, 8 data bits LSB first, optional parity, stop
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state     <= IDLE;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
      last_sent <= FREE_RUN;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= START;
            txd_r     <= 1'b0;
            busy_r    <= 1'b1;
            shreg     <= cmd_byte_p1;
            par_bit   <= ^cmd_byte_p1;
            last_sent <= cmd_byte_p1;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd_r   <= shreg[0];
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef ZIGBEE_TX_PARITY_EN
              state <= PARITY;
              txd_r <= par_bit;
`else
              state     <= STOP;
              txd_r     <= 1'b1;
              tx_done_r <= (BIT_CYC == 1);
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd_r   <= shreg[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
`ifdef ZIGBEE_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            txd_r     <= 1'b1;
            cyc_cnt   <= '0;
            tx_done_r <= (BIT_CYC == 1);
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
`endif
        STOP: begin
          // tx_done is registered, so it is raised one cycle ahead to land on the last stop cycle
          if (bit_end) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
            cyc_cnt   <= '0;
          end else begin
            cyc_cnt   <= cyc_cnt + CYC_W'(1);
            tx_done_r <= (cyc_cnt == CYC_W'(BIT_CYC - 2));
          end
        end
        default: begin
          state     <= IDLE;
          txd_r     <= 1'b1;
          busy_r    <= 1'b0;
          tx_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.txd      = txd_r;
  assign bus.busy     = busy_r;
  assign bus.tx_done  = tx_done_r;
  assign bus.cmd_byte = cmd_byte_p1;

endmodule
